// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver: logical segment levels,
// hex decode table and a constant clog2 used for counter widths.
package seg7_defs;

   localparam logic SEG_ON  = 1'b1;
   localparam logic SEG_OFF = 1'b0;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Active-high segment pattern, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0:    s = 7'h3F;
         4'h1:    s = 7'h06;
         4'h2:    s = 7'h5B;
         4'h3:    s = 7'h4F;
         4'h4:    s = 7'h66;
         4'h5:    s = 7'h6D;
         4'h6:    s = 7'h7D;
         4'h7:    s = 7'h07;
         4'h8:    s = 7'h7F;
         4'h9:    s = 7'h6F;
         4'hA:    s = 7'h77;
         4'hB:    s = 7'h7C;
         4'hC:    s = 7'h39;
         4'hD:    s = 7'h5E;
         4'hE:    s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_slot_timer.sv
// Slot prescaler and digit index counter; flags the guard band at the start
// of every slot and the frame boundary when the index wraps to digit 0.
module seg7_slot_timer
   import seg7_defs::*;
#(
   parameter int DIGITS    = 4,
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 16,
   localparam int PW = clog2(SCAN_DIV),
   localparam int IW = clog2(DIGITS)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic          slot_tick_o,
   output logic          frame_tick_o,
   output logic [IW-1:0] index_o,
   output logic          guard_o
);

   localparam logic [PW-1:0] LAST_CNT = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [IW-1:0] idx_q, idx_d;

   assign slot_tick_o  = (presc_q == LAST_CNT);
   assign frame_tick_o = slot_tick_o && (idx_q == LAST_IDX);
   assign guard_o      = (presc_q < PW'(BLANK_CYC));
   assign index_o      = idx_q;

   always_comb begin
      presc_d = presc_q + 1'b1;
      idx_d   = idx_q;
      if (slot_tick_o) begin
         presc_d = '0;
         idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc_q <= '0;
         idx_q   <= '0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver: load/ack staging, frame-synchronous shadow
// update, leading-zero blanking and registered anode/segment outputs.
module seg7_scan_driver
   import seg7_defs::*;
#(
   parameter int DIGITS     = 4,
   parameter int SCAN_DIV   = 100000,
   parameter int BLANK_CYC  = 16,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clock_in,
   input  logic                  Rst,
   input  logic [4*DIGITS-1:0]   value_in,
   input  logic                  load,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank_lz,
   output logic                  load_ack,
   output logic [6:0]            seg_out,
   output logic                  dp_out,
   output logic [DIGITS-1:0]     an_out
);

   localparam int   IW  = clog2(DIGITS);
   localparam logic POL = (ACTIVE_LOW != 0);

   logic          slot_tick, frame_tick, guard;
   logic [IW-1:0] idx;

   seg7_slot_timer #(
      .DIGITS    (DIGITS),
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_timer (
      .clk_i        (clock_in),
      .rst_i        (Rst),
      .slot_tick_o  (slot_tick),
      .frame_tick_o (frame_tick),
      .index_o      (idx),
      .guard_o      (guard)
   );

   logic [4*DIGITS-1:0] stg_val_q, stg_val_d, shd_val_q, shd_val_d;
   logic [DIGITS-1:0]   stg_dp_q, stg_dp_d, shd_dp_q, shd_dp_d;
   logic                stg_blz_q, stg_blz_d, shd_blz_q, shd_blz_d;
   logic                pending_q, pending_d, ack_q, ack_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic [DIGITS-1:0]   an_q, an_d;

   logic [3:0]          nib [DIGITS];
   logic [DIGITS:0]     lz_chain;
   logic [DIGITS-1:0]   blank_vec;

   // lz_chain[k] = nibbles k..DIGITS-1 are all zero
   assign lz_chain[DIGITS] = 1'b1;
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign nib[gi]      = shd_val_q[4*gi +: 4];
         assign lz_chain[gi] = lz_chain[gi+1] && (nib[gi] == 4'h0);
         if (gi == 0) begin : g_units
            assign blank_vec[gi] = 1'b0;
         end else begin : g_upper
            assign blank_vec[gi] = shd_blz_q && lz_chain[gi];
         end
      end
   endgenerate

   always_comb begin
      stg_val_d = stg_val_q;
      stg_dp_d  = stg_dp_q;
      stg_blz_d = stg_blz_q;
      shd_val_d = shd_val_q;
      shd_dp_d  = shd_dp_q;
      shd_blz_d = shd_blz_q;
      pending_d = pending_q;
      ack_d     = 1'b0;
      seg_d     = seg_q;
      dp_d      = dp_q;

      if (slot_tick && frame_tick) begin
         if (pending_q) begin
            shd_val_d = stg_val_q;
            shd_dp_d  = stg_dp_q;
            shd_blz_d = stg_blz_q;
            ack_d     = 1'b1;
         end
         pending_d = 1'b0;
      end

      // A load on the boundary cycle re-arms pending for the next frame
      if (load) begin
         stg_val_d = value_in;
         stg_dp_d  = dp_in;
         stg_blz_d = blank_lz;
         pending_d = 1'b1;
      end

      an_d = guard ? {DIGITS{SEG_OFF}} : ({{(DIGITS-1){1'b0}}, 1'b1} << idx);
      an_d = an_d ^ {DIGITS{POL}};

      // Segment data only moves while the anodes are dark
      if (guard) begin
         seg_d = blank_vec[idx] ? {7{SEG_OFF}} : hex_to_seg(nib[idx]);
         seg_d = seg_d ^ {7{POL}};
         dp_d  = shd_dp_q[idx] ^ POL;
      end
   end

   always_ff @(posedge clock_in or posedge Rst) begin
      if (Rst) begin
         stg_val_q <= '0;
         stg_dp_q  <= '0;
         stg_blz_q <= 1'b0;
         shd_val_q <= '0;
         shd_dp_q  <= '0;
         shd_blz_q <= 1'b0;
         pending_q <= 1'b0;
         ack_q     <= 1'b0;
         seg_q     <= {7{POL}};
         dp_q      <= POL;
         an_q      <= {DIGITS{POL}};
      end else begin
         stg_val_q <= stg_val_d;
         stg_dp_q  <= stg_dp_d;
         stg_blz_q <= stg_blz_d;
         shd_val_q <= shd_val_d;
         shd_dp_q  <= shd_dp_d;
         shd_blz_q <= shd_blz_d;
         pending_q <= pending_d;
         ack_q     <= ack_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         an_q      <= an_d;
      end
   end

   assign load_ack = ack_q;
   assign seg_out  = seg_q;
   assign dp_out   = dp_q;
   assign an_out   = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, active-low.
module tb_seg7_scan_driver;

   logic        clk;
   logic        rst;
   logic [15:0] value_in;
   logic        load;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic        load_ack;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [3:0]  an_out;

   int total = 0;
   int bad   = 0;
   int ack_cnt = 0;

   seg7_scan_driver #(
      .DIGITS     (4),
      .SCAN_DIV   (4),
      .BLANK_CYC  (1),
      .ACTIVE_LOW (1)
   ) dut (
      .clock_in (clk),
      .Rst      (rst),
      .value_in (value_in),
      .load     (load),
      .dp_in    (dp_in),
      .blank_lz (blank_lz),
      .load_ack (load_ack),
      .seg_out  (seg_out),
      .dp_out   (dp_out),
      .an_out   (an_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (load_ack === 1'b1) ack_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Expected segment patterns are the physical (active-low) levels, digit 3 first
   typedef struct packed {
      logic [15:0] val;
      logic [3:0]  dp;
      logic        blz;
      logic [27:0] segs;
      logic [3:0]  dpo;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic b);
      value_in = v;
      dp_in    = d;
      blank_lz = b;
      load     = 1'b1;
      tick();
      load     = 1'b0;
   endtask

   task automatic wait_ack(input string name);
      int n;
      n = 0;
      while (load_ack !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      chk(name, {31'd0, load_ack}, 32'd1);
   endtask

   task automatic wait_digit0(input string name);
      int n;
      n = 0;
      while (an_out !== 4'hE && n < 40) begin
         tick();
         n++;
      end
      chk(name, {28'd0, an_out}, 32'hE);
   endtask

   // Land just after the digit-0 guard sample (state = digit 0, count 1)
   task automatic align_frame();
      logic [3:0] prev;
      int n;
      bit found;
      found = 0;
      prev  = an_out;
      n     = 0;
      while (!found && n < 40) begin
         tick();
         n++;
         if (prev == 4'h7 && an_out == 4'hF) found = 1;
         prev = an_out;
      end
      chk("align_frame", {31'd0, found}, 32'd1);
   endtask

   task automatic scan_frame(input string tag, input logic [27:0] segs, input logic [3:0] dpo);
      logic [3:0] exp_an;
      wait_digit0({tag, "_align"});
      for (int d = 0; d < 4; d++) begin
         exp_an = ~(4'd1 << d);
         chk($sformatf("%s_an%0d", tag, d), {28'd0, an_out}, {28'd0, exp_an});
         chk($sformatf("%s_seg%0d", tag, d), {25'd0, seg_out}, {25'd0, segs[d*7 +: 7]});
         chk($sformatf("%s_dp%0d", tag, d), {31'd0, dp_out}, {31'd0, dpo[d]});
         if (d < 3) repeat (4) tick();
      end
   endtask

   initial begin
      int a0;
      int e0;

      vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
      vecs[1] = '{16'h0007, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1111};
      vecs[2] = '{16'h0000, 4'b0100, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1011};
      vecs[3] = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
      vecs[4] = '{16'h89AB, 4'b1001, 1'b0, {7'h00, 7'h10, 7'h08, 7'h03}, 4'b0110};
      vecs[5] = '{16'hCDEF, 4'b0000, 1'b1, {7'h46, 7'h21, 7'h06, 7'h0E}, 4'b1111};
      vecs[6] = '{16'h0506, 4'b0000, 1'b1, {7'h7F, 7'h12, 7'h40, 7'h02}, 4'b1111};
      vecs[7] = '{16'h0050, 4'b0010, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1101};

      rst      = 1'b0;
      load     = 1'b0;
      value_in = '0;
      dp_in    = '0;
      blank_lz = 1'b0;
      #2 rst = 1'b1;

      // Reset hold: everything dark, no ack
      repeat (4) begin
         tick();
         chk("rst_an", {28'd0, an_out}, 32'hF);
         chk("rst_seg", {25'd0, seg_out}, 32'h7F);
         chk("rst_dp", {31'd0, dp_out}, 32'd1);
         chk("rst_ack", {31'd0, load_ack}, 32'd0);
      end
      rst = 1'b0;
      $display("reset released");

      // First load after reset: ack lands the cycle after the first boundary
      tick();
      tick();
      value_in = 16'h1234;
      dp_in    = 4'b0000;
      blank_lz = 1'b0;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      for (int e = 4; e <= 20; e++) begin
         tick();
         chk($sformatf("first_ack_e%0d", e), {31'd0, load_ack}, {31'd0, (e == 16)});
         if (e == 17) begin
            chk("first_guard_an", {28'd0, an_out}, 32'hF);
            chk("first_guard_seg", {25'd0, seg_out}, 32'h19);
         end
         if (e == 18) begin
            chk("first_d0_an", {28'd0, an_out}, 32'hE);
            chk("first_d0_seg", {25'd0, seg_out}, 32'h19);
         end
      end
      $display("load 1234 acked at edge 16");

      for (int i = 0; i < 8; i++) begin
         a0 = ack_cnt;
         do_load(vecs[i].val, vecs[i].dp, vecs[i].blz);
         wait_ack($sformatf("vec%0d_ack", i));
         scan_frame($sformatf("vec%0d", i), vecs[i].segs, vecs[i].dpo);
         chk($sformatf("vec%0d_ackcount", i), ack_cnt - a0, 32'd1);
         $display("vec %0d value=%h dp=%b blz=%0d displayed", i, vecs[i].val, vecs[i].dp, vecs[i].blz);
      end

      // Two loads in one frame: last wins, single ack
      wait_digit0("double_align");
      a0 = ack_cnt;
      do_load(16'hAAAA, 4'b0000, 1'b0);
      tick();
      do_load(16'h5555, 4'b0000, 1'b0);
      wait_ack("double_ack");
      scan_frame("double", {7'h12, 7'h12, 7'h12, 7'h12}, 4'b1111);
      repeat (20) tick();
      chk("double_ackcount", ack_cnt - a0, 32'd1);
      $display("double load AAAA then 5555: one ack, shows 5555");

      // Load exactly on the frame-tick cycle with nothing pending
      align_frame();
      repeat (14) tick();
      a0 = ack_cnt;
      value_in = 16'h4321;
      dp_in    = 4'b0000;
      blank_lz = 1'b0;
      load     = 1'b1;
      tick();
      load     = 1'b0;
      chk("boundary_no_ack", {31'd0, load_ack}, 32'd0);
      for (int k = 16; k <= 33; k++) begin
         tick();
         chk($sformatf("boundary_ack_k%0d", k), {31'd0, load_ack}, {31'd0, (k == 31)});
      end
      scan_frame("boundary", {7'h19, 7'h30, 7'h24, 7'h79}, 4'b1111);
      chk("boundary_ackcount", ack_cnt - a0, 32'd1);
      $display("load on boundary cycle: acked one frame later");

      // Asynchronous reset mid-slot with a value pending
      wait_digit0("rst_mid_align");
      do_load(16'hFFFF, 4'b1111, 1'b0);
      tick();
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_an", {28'd0, an_out}, 32'hF);
      chk("rst_mid_seg", {25'd0, seg_out}, 32'h7F);
      chk("rst_mid_dp", {31'd0, dp_out}, 32'd1);
      chk("rst_mid_ack", {31'd0, load_ack}, 32'd0);
      repeat (3) tick();
      rst = 1'b0;
      e0 = ack_cnt;
      tick();
      chk("post_rst_guard_an", {28'd0, an_out}, 32'hF);
      chk("post_rst_guard_seg", {25'd0, seg_out}, 32'h40);
      tick();
      chk("post_rst_d0_an", {28'd0, an_out}, 32'hE);
      chk("post_rst_d0_seg", {25'd0, seg_out}, 32'h40);
      chk("post_rst_d0_dp", {31'd0, dp_out}, 32'd1);
      repeat (40) tick();
      chk("post_rst_no_ack", ack_cnt - e0, 32'd0);
      $display("mid-frame reset: pending dropped, shows 0");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
